// File: rtl/interpolator.sv
// Polyphase FIR interpolator: upsamples a signed stream by FACTOR and
// low-pass filters it with the prototype filter COEFFS (Q1.(COEFF_WIDTH-1)).
// Each accepted input yields FACTOR outputs, phase 0 first, on a
// valid/ready output port.
// Optional feature: define INTERPOLATOR_SAT_EN to clamp outputs to the
// DATA_WIDTH range; otherwise results wrap in two's complement.
module interpolator #(
   parameter int DATA_WIDTH  = 12,
   parameter int COEFF_WIDTH = 7,
   parameter int NUM_TAPS    = 8,
   parameter int FACTOR      = 4,
   parameter logic [NUM_TAPS*COEFF_WIDTH-1:0] COEFFS = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] x,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] y
);

   localparam int TPP       = NUM_TAPS / FACTOR;
   localparam int ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(TPP);
   localparam int PW        = $clog2(FACTOR);
   localparam logic [PW-1:0] LAST_PHASE = PW'(FACTOR - 1);

   typedef enum logic [0:0] {IDLE, EMIT} state_t;

   state_t                         state_reg, state_next;
   logic [PW-1:0]                  p_reg, p_next;
   logic signed [DATA_WIDTH-1:0]   y_reg, y_next;
   logic signed [DATA_WIDTH-1:0]   d_reg [TPP];
   logic signed [DATA_WIDTH-1:0]   line_next [TPP];
   logic signed [ACC_WIDTH-1:0]    prod [TPP];
   logic signed [ACC_WIDTH-1:0]    acc_sum;
   logic signed [DATA_WIDTH-1:0]   y_res;
   logic [PW-1:0]                  phase_sel;
   logic                           accept;
   logic                           out_hs;
   logic                           last_phase;

   assign out_valid  = (state_reg == EMIT);
   assign y          = y_reg;
   assign last_phase = (p_reg == LAST_PHASE);
   // A new sample may enter while idle or while the last phase is being taken.
   assign in_ready   = !out_valid || (out_ready && last_phase);
   assign accept     = in_valid && in_ready;
   assign out_hs     = out_valid && out_ready;

   // Phase of the result that will be loaded into y on this edge: phase 0 for
   // a new sample, otherwise the next phase of the current sample.
   always_comb begin
      phase_sel = '0;
      if (!accept && !last_phase) begin
         phase_sel = p_reg + PW'(1);
      end
   end

   // One multiplier per tap; on accept the product uses the post-shift line
   // so the phase-0 result is ready on the same edge the sample arrives.
   for (genvar gi = 0; gi < TPP; gi++) begin : g_tap
      logic signed [COEFF_WIDTH-1:0] coef;
      logic signed [DATA_WIDTH-1:0]  samp;
      logic signed [ACC_WIDTH-1:0]   coef_ext;
      logic signed [ACC_WIDTH-1:0]   samp_ext;

      if (gi == 0) begin : g_head
         assign line_next[gi] = x;
      end else begin : g_tail
         assign line_next[gi] = d_reg[gi-1];
      end

      assign coef     = COEFFS[(int'(phase_sel) + gi*FACTOR)*COEFF_WIDTH +: COEFF_WIDTH];
      assign samp     = accept ? line_next[gi] : d_reg[gi];
      assign coef_ext = coef;
      assign samp_ext = samp;
      assign prod[gi] = coef_ext * samp_ext;
   end

   // Sum the tap products at full precision.
   always_comb begin
      acc_sum = '0;
      for (int k = 0; k < TPP; k++) begin
         acc_sum = acc_sum + prod[k];
      end
   end

`ifdef INTERPOLATOR_SAT_EN
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   logic signed [ACC_WIDTH-1:0] r;

   // Floor-rescale from Q1.(COEFF_WIDTH-1) and clamp to the output range.
   always_comb begin
      r = acc_sum >>> (COEFF_WIDTH - 1);
      if (r > SAT_MAX) begin
         y_res = SAT_MAX[DATA_WIDTH-1:0];
      end else if (r < SAT_MIN) begin
         y_res = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         y_res = r[DATA_WIDTH-1:0];
      end
   end
`else
   // Floor-rescale from Q1.(COEFF_WIDTH-1) and keep the low bits (wrap).
   always_comb begin
      y_res = DATA_WIDTH'(acc_sum >>> (COEFF_WIDTH - 1));
   end
`endif

   // Next-state logic: accept wins over the last-phase handshake so that
   // back-to-back samples stream without a bubble.
   always_comb begin
      state_next = state_reg;
      p_next     = p_reg;
      y_next     = y_reg;
      if (accept) begin
         state_next = EMIT;
         p_next     = '0;
         y_next     = y_res;
      end else if (out_hs) begin
         if (!last_phase) begin
            p_next = p_reg + PW'(1);
            y_next = y_res;
         end else begin
            state_next = IDLE;
            p_next     = '0;
         end
      end
   end

   // State, phase, output and delay-line registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         p_reg     <= '0;
         y_reg     <= '0;
         for (int k = 0; k < TPP; k++) begin
            d_reg[k] <= '0;
         end
      end else begin
         state_reg <= state_next;
         p_reg     <= p_next;
         y_reg     <= y_next;
         if (accept) begin
            for (int k = 0; k < TPP; k++) begin
               d_reg[k] <= line_next[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_interpolator.sv
// Scoreboard bench for interpolator: instance 0 uses h[i]=i+1 (impulse,
// backpressure, back-to-back, idle gap, reset), instance 1 uses h=63
// (overflow handling). Expected outputs are queued when a sample is sent and
// compared by a monitor on every output handshake.
module tb_interpolator;

   localparam int DW = 12;
   localparam int CW = 7;
   localparam logic [8*CW-1:0] COEFFS_IMP =
      {7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
   localparam logic [8*CW-1:0] COEFFS_SAT = {8{7'd63}};

`ifdef INTERPOLATOR_SAT_EN
   localparam int S_POS = 2047;
   localparam int S_NEG = -2048;
`else
   localparam int S_POS = -66;
   localparam int S_NEG = 64;
`endif

   typedef struct {
      int   val;
      logic last;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid  [2];
   logic                 in_ready  [2];
   logic                 out_valid [2];
   logic                 out_ready [2];
   logic signed [DW-1:0] x [2];
   logic signed [DW-1:0] y [2];

   exp_t exp_q [2][$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   interpolator #(
      .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(8), .FACTOR(4), .COEFFS(COEFFS_IMP)
   ) u_imp (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .x(x[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .y(y[0])
   );

   interpolator #(
      .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(8), .FACTOR(4), .COEFFS(COEFFS_SAT)
   ) u_sat (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .x(x[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .y(y[1])
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   // Offer one sample; once in_ready is seen, queue its four expected phases.
   task automatic send(input int i, input int v, input int e0, input int e1,
                       input int e2, input int e3, output time t_acc);
      int n = 0;
      int e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      t_acc = 0;
      in_valid[i] = 1'b1;
      x[i] = DW'(v);
      @(negedge clk);
      while (!in_ready[i] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[i]) begin
         chk("accept_timeout", 0, 1);
         in_valid[i] = 1'b0;
         return;
      end
      for (int k = 0; k < 4; k++) begin
         exp_q[i].push_back('{val: e[k], last: (k == 3)});
      end
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid[i] = 1'b0;
   endtask

   // Wait until every queued output has been handshaken.
   task automatic drain(input int i);
      int n = 0;
      while (exp_q[i].size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", exp_q[i].size(), 0);
      #1;
   endtask

   // Monitor: compare every handshaken output and the in_ready relation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output[%0d]: got y=%0d required no output", i, y[i]);
               end else begin
                  e = exp_q[i].pop_front();
                  $display("out[%0d] y=%0d expected=%0d in_ready=%0d", i, y[i], e.val, in_ready[i]);
                  chk("y_value", int'(y[i]), e.val);
                  chk("in_ready_at_handshake", int'(in_ready[i]), int'(e.last));
               end
            end else if (out_valid[i]) begin
               chk("in_ready_stalled", int'(in_ready[i]), 0);
            end else begin
               chk("in_ready_idle", int'(in_ready[i]), 1);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      time t0, t1, t2, tx;
      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
         x[i]         = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state
      for (int i = 0; i < 2; i++) begin
         chk("reset_y", int'(y[i]), 0);
         chk("reset_out_valid", int'(out_valid[i]), 0);
         chk("reset_in_ready", int'(in_ready[i]), 1);
      end

      // Impulse response, issued back-to-back
      send(0, 64, 1, 2, 3, 4, t0);
      send(0, 0, 5, 6, 7, 8, t1);
      send(0, 0, 0, 0, 0, 0, t2);
      chk("b2b_spacing_1", int'(t1 - t0), 40);
      chk("b2b_spacing_2", int'(t2 - t1), 40);
      drain(0);

      // Idle gap: output idles right after the last phase
      chk("idle_out_valid", int'(out_valid[0]), 0);
      chk("idle_in_ready", int'(in_ready[0]), 1);

      // One-cycle latency, then backpressure held at phase 1
      send(0, 64, 1, 2, 3, 4, tx);
      chk("latency_out_valid", int'(out_valid[0]), 1);
      chk("latency_y", int'(y[0]), 1);
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("stall_y", int'(y[0]), 2);
         chk("stall_out_valid", int'(out_valid[0]), 1);
         chk("stall_in_ready", int'(in_ready[0]), 0);
      end
      out_ready[0] = 1'b1;
      send(0, 0, 5, 6, 7, 8, tx);
      drain(0);

      // Reset in the middle of a burst, at phase 2
      send(0, 64, 1, 2, 3, 4, tx);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("pre_reset_y", int'(y[0]), 3);
      rst_n = 1'b0;
      exp_q[0].delete();
      exp_q[1].delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("post_reset_y", int'(y[0]), 0);
      chk("post_reset_out_valid", int'(out_valid[0]), 0);
      chk("post_reset_in_ready", int'(in_ready[0]), 1);
      send(0, 64, 1, 2, 3, 4, tx);
      send(0, 0, 5, 6, 7, 8, tx);
      drain(0);

      // Overflow handling with all coefficients at 63
      send(1, 2047, 2015, 2015, 2015, 2015, tx);
      send(1, 2047, S_POS, S_POS, S_POS, S_POS, tx);
      send(1, -2048, -1, -1, -1, -1, tx);
      send(1, -2048, S_NEG, S_NEG, S_NEG, S_NEG, tx);
      drain(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
